// File: rtl/spi_flash_read_arbiter.sv
// Two-requester round-robin front end for the quad-SPI flash read engine.
// Keeps one read outstanding at a time. Addresses outside the flash window are
// answered locally with DECERR. A wait for read data that runs too long is
// answered with SLVERR, and the engine's late beat is discarded afterwards.
// Every output is driven directly from a register.
module spi_flash_read_arbiter #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] FLASH_BYTES    = 'h400000,
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [1:0]              s_arvalid,
  input  logic [2*ADDR_WIDTH-1:0] s_araddr,
  output logic [1:0]              s_arready,
  output logic [1:0]              s_rvalid,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  input  logic [1:0]              s_rready,
  output logic                    m_arvalid,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  input  logic                    m_arready,
  input  logic                    m_rvalid,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  output logic                    m_rready,
  output logic                    timeout,
  output logic                    busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_ISSUE,
    ST_WAIT_R,
    ST_RESP,
    ST_DRAIN
  } state_t;

  state_t                r_state,      w_state_next;
  logic                  r_grant,      w_grant_next;
  logic                  r_last_grant, w_last_grant_next;
  logic                  r_late,       w_late_next;
  logic [CNT_W-1:0]      r_cnt,        w_cnt_next;

  logic [1:0]            r_s_arready,  w_s_arready_next;
  logic [1:0]            r_s_rvalid,   w_s_rvalid_next;
  logic [DATA_WIDTH-1:0] r_s_rdata,    w_s_rdata_next;
  logic [1:0]            r_s_rresp,    w_s_rresp_next;
  logic                  r_m_arvalid,  w_m_arvalid_next;
  logic [ADDR_WIDTH-1:0] r_m_araddr,   w_m_araddr_next;
  logic                  r_m_rready,   w_m_rready_next;
  logic                  r_timeout,    w_timeout_next;
  logic                  r_busy,       w_busy_next;

  logic [ADDR_WIDTH-1:0] w_sel_addr;

  // Address of the granted requester; it is held stable while ACCEPT runs.
  assign w_sel_addr = r_grant ? s_araddr[2*ADDR_WIDTH-1 -: ADDR_WIDTH]
                              : s_araddr[ADDR_WIDTH-1:0];

  // Next-state logic. Output registers are loaded from the state being entered,
  // so each output is valid in the first cycle of its state.
  always_comb begin
    w_state_next      = r_state;
    w_grant_next      = r_grant;
    w_last_grant_next = r_last_grant;
    w_late_next       = r_late;
    w_cnt_next        = r_cnt;
    w_s_rdata_next    = r_s_rdata;
    w_s_rresp_next    = r_s_rresp;
    w_m_araddr_next   = r_m_araddr;
    w_timeout_next    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (|s_arvalid) begin
          // A tie goes to whoever was not served last.
          w_grant_next = (s_arvalid == 2'b11) ? ~r_last_grant : s_arvalid[1];
          w_state_next = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        w_last_grant_next = r_grant;
        if (w_sel_addr >= FLASH_BYTES) begin
          w_s_rresp_next = RESP_DECERR;
          w_s_rdata_next = '0;
          w_state_next   = ST_RESP;
        end else begin
          w_m_araddr_next = w_sel_addr;
          w_state_next    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // No timeout here: once presented, an AR is never withdrawn.
        if (m_arready) begin
          w_cnt_next   = '0;
          w_state_next = ST_WAIT_R;
        end
      end
      ST_WAIT_R: begin
        if (m_rvalid) begin
          w_s_rdata_next = m_rdata;
          w_s_rresp_next = m_rresp;
          w_state_next   = ST_RESP;
        end else if (r_cnt == CNT_LAST) begin
          // The engine still owes a beat; it is discarded in DRAIN.
          w_s_rdata_next = '0;
          w_s_rresp_next = RESP_SLVERR;
          w_timeout_next = 1'b1;
          w_late_next    = 1'b1;
          w_state_next   = ST_RESP;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (s_rready[r_grant]) begin
          w_state_next = r_late ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (m_rvalid) begin
          w_late_next  = 1'b0;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    w_s_arready_next = (w_state_next == ST_ACCEPT) ? {w_grant_next, ~w_grant_next} : 2'b00;
    w_s_rvalid_next  = (w_state_next == ST_RESP)   ? {w_grant_next, ~w_grant_next} : 2'b00;
    w_m_arvalid_next = (w_state_next == ST_ISSUE);
    w_m_rready_next  = (w_state_next == ST_WAIT_R) || (w_state_next == ST_DRAIN);
    w_busy_next      = (w_state_next != ST_IDLE);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_late       <= 1'b0;
      r_cnt        <= '0;
      r_s_arready  <= 2'b00;
      r_s_rvalid   <= 2'b00;
      r_s_rdata    <= '0;
      r_s_rresp    <= RESP_OKAY;
      r_m_arvalid  <= 1'b0;
      r_m_araddr   <= '0;
      r_m_rready   <= 1'b0;
      r_timeout    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_grant      <= w_grant_next;
      r_last_grant <= w_last_grant_next;
      r_late       <= w_late_next;
      r_cnt        <= w_cnt_next;
      r_s_arready  <= w_s_arready_next;
      r_s_rvalid   <= w_s_rvalid_next;
      r_s_rdata    <= w_s_rdata_next;
      r_s_rresp    <= w_s_rresp_next;
      r_m_arvalid  <= w_m_arvalid_next;
      r_m_araddr   <= w_m_araddr_next;
      r_m_rready   <= w_m_rready_next;
      r_timeout    <= w_timeout_next;
      r_busy       <= w_busy_next;
    end
  end

  assign s_arready = r_s_arready;
  assign s_rvalid  = r_s_rvalid;
  assign s_rdata   = r_s_rdata;
  assign s_rresp   = r_s_rresp;
  assign m_arvalid = r_m_arvalid;
  assign m_araddr  = r_m_araddr;
  assign m_rready  = r_m_rready;
  assign timeout   = r_timeout;
  assign busy      = r_busy;

endmodule

// File: tb/tb_spi_flash_read_arbiter.sv
// Directed bench for spi_flash_read_arbiter; the bench itself plays both
// requesters and the flash read engine.
module tb_spi_flash_read_arbiter;

  logic        ACLK;
  logic        ARESETn;
  logic [1:0]  s_arvalid;
  logic [63:0] s_araddr;
  logic [1:0]  s_arready;
  logic [1:0]  s_rvalid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic [1:0]  s_rready;
  logic        m_arvalid;
  logic [31:0] m_araddr;
  logic        m_arready;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rready;
  logic        timeout;
  logic        busy;

  int   n_checks   = 0;
  int   n_errors   = 0;
  int   to_pulses  = 0;
  int   marv_rises = 0;
  logic prev_marv  = 1'b0;
  logic s1_rv_seen = 1'b0;

  spi_flash_read_arbiter #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .FLASH_BYTES   (32'h400000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .s_arvalid(s_arvalid),
    .s_araddr (s_araddr),
    .s_arready(s_arready),
    .s_rvalid (s_rvalid),
    .s_rdata  (s_rdata),
    .s_rresp  (s_rresp),
    .s_rready (s_rready),
    .m_arvalid(m_arvalid),
    .m_araddr (m_araddr),
    .m_arready(m_arready),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata),
    .m_rresp  (m_rresp),
    .m_rready (m_rready),
    .timeout  (timeout),
    .busy     (busy)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Safety net in case something upstream of a bounded loop stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge; track monitored events.
  task automatic tick();
    @(posedge ACLK);
    #1;
    if (timeout === 1'b1) to_pulses++;
    if (s_rvalid[1] === 1'b1) s1_rv_seen = 1'b1;
    if (m_arvalid === 1'b1 && prev_marv !== 1'b1) marv_rises++;
    prev_marv = m_arvalid;
  endtask

  // One engine-backed read: request, AR handshake, data after rlat WAIT_R
  // cycles, optional bp cycles of response back-pressure, then completion.
  task automatic do_read(input int req, input logic [31:0] addr, input int rlat, input int bp,
                         input logic [31:0] data, input logic [1:0] resp, input string tag);
    int         g;
    logic       stable;
    logic [1:0] exp_rv;
    exp_rv = (req == 1) ? 2'b10 : 2'b01;
    if (req == 1) s_araddr[63:32] = addr;
    else          s_araddr[31:0]  = addr;
    s_arvalid[req] = 1'b1;
    g = 0;
    while (s_arready[req] !== 1'b1 && g < 20) begin tick(); g++; end
    chk({tag, "_arready"}, s_arready, exp_rv);
    tick();
    s_arvalid[req] = 1'b0;
    g = 0;
    while (m_arvalid !== 1'b1 && g < 20) begin tick(); g++; end
    chk({tag, "_araddr"}, {m_arvalid, m_araddr}, {1'b1, addr});
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    repeat (rlat) tick();
    m_rvalid = 1'b1; m_rdata = data; m_rresp = resp;
    tick();
    m_rvalid = 1'b0;
    chk({tag, "_rvalid"}, s_rvalid, exp_rv);
    chk({tag, "_rdata"}, {s_rresp, s_rdata}, {resp, data});
    stable = 1'b1;
    for (int i = 0; i < bp; i++) begin
      tick();
      if (s_rvalid !== exp_rv || s_rdata !== data || s_rresp !== resp) stable = 1'b0;
    end
    if (bp > 0) chk({tag, "_hold"}, stable, 1'b1);
    s_rready[req] = 1'b1;
    tick();
    s_rready[req] = 1'b0;
    chk({tag, "_done"}, {s_rvalid, busy}, 3'b000);
  endtask

  initial begin
    int         g;
    int         nw;
    int         marv0;
    int         ngrant, nresp, gcnt0, gcnt1;
    logic [5:0] order;
    logic       drop0, drop1, eng_pend, rv_drv;
    logic [31:0] eng_addr;

    ARESETn = 1'b0; s_arvalid = 2'b00; s_araddr = '0; s_rready = 2'b00;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;

    // ---- Reset state ----
    repeat (3) tick();
    chk("rst_ctrl", {s_arready, s_rvalid, s_rresp, m_arvalid, m_rready, timeout, busy}, '0);
    chk("rst_data", {s_rdata, m_araddr}, '0);
    ARESETn = 1'b1;
    tick();
    chk("rst_idle", busy, 1'b0);

    // ---- A: S0 read 0x100, latency and stability ----
    s1_rv_seen = 1'b0;
    s_araddr[31:0] = 32'h100;
    s_arvalid = 2'b01;
    tick();                                  // edge 0 seen in IDLE
    chk("a_arready_c1", {s_arready, busy, m_arvalid}, {2'b01, 1'b1, 1'b0});
    tick();
    s_arvalid = 2'b00;
    chk("a_issue_c2", {s_arready, m_arvalid, m_araddr}, {2'b00, 1'b1, 32'h100});
    tick(); tick();
    chk("a_ar_held", {m_arvalid, m_araddr}, {1'b1, 32'h100});
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    chk("a_wait_r", {m_arvalid, m_rready}, 2'b01);
    repeat (11) tick();
    m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF; m_rresp = 2'b00;
    tick();
    m_rvalid = 1'b0;
    chk("a_rvalid", {s_rvalid, m_rready}, {2'b01, 1'b0});
    chk("a_rdata", {s_rresp, s_rdata}, {2'b00, 32'hDEADBEEF});
    s_rready = 2'b01;
    tick();
    s_rready = 2'b00;
    chk("a_done", {s_rvalid, busy}, 3'b000);
    chk("a_s1_quiet", s1_rv_seen, 1'b0);

    // ---- Last valid word of the window ----
    do_read(0, 32'h3FFFFC, 3, 0, 32'h5A5A1234, 2'b00, "b_edge");

    // ---- C: S1 read at FLASH_BYTES -> DECERR, engine untouched ----
    marv0 = marv_rises;
    s_araddr[63:32] = 32'h400000;
    s_arvalid = 2'b10;
    g = 0;
    while (s_arready[1] !== 1'b1 && g < 20) begin tick(); g++; end
    chk("c_arready", s_arready, 2'b10);
    tick();
    s_arvalid = 2'b00;
    g = 0;
    while (s_rvalid[1] !== 1'b1 && g < 20) begin tick(); g++; end
    chk("c_rvalid", s_rvalid, 2'b10);
    chk("c_decerr", {s_rresp, s_rdata}, {2'b11, 32'h0});
    s_rready = 2'b10;
    tick();
    s_rready = 2'b00;
    chk("c_done", {s_rvalid, busy}, 3'b000);
    chk("c_no_marvalid", marv_rises - marv0, 0);

    // ---- Round robin: both hold valid for three reads each ----
    marv0 = marv_rises;
    s_araddr = {32'h20, 32'h10};
    s_arvalid = 2'b11;
    s_rready = 2'b11;
    ngrant = 0; nresp = 0; gcnt0 = 0; gcnt1 = 0; order = '0;
    drop0 = 1'b0; drop1 = 1'b0; eng_pend = 1'b0; rv_drv = 1'b0; eng_addr = '0;
    for (int cyc = 0; cyc < 300 && nresp < 6; cyc++) begin
      tick();
      if (drop0) begin s_arvalid[0] = 1'b0; drop0 = 1'b0; end
      if (drop1) begin s_arvalid[1] = 1'b0; drop1 = 1'b0; end
      if (s_arready[0] === 1'b1) begin
        if (ngrant < 6) order[ngrant] = 1'b0;
        ngrant++; gcnt0++;
        if (gcnt0 == 3) drop0 = 1'b1;
      end
      if (s_arready[1] === 1'b1) begin
        if (ngrant < 6) order[ngrant] = 1'b1;
        ngrant++; gcnt1++;
        if (gcnt1 == 3) drop1 = 1'b1;
      end
      if (m_arready) begin
        m_arready = 1'b0;
      end else if (m_arvalid === 1'b1) begin
        m_arready = 1'b1; eng_addr = m_araddr; eng_pend = 1'b1;
      end
      if (rv_drv) begin
        m_rvalid = 1'b0; rv_drv = 1'b0; eng_pend = 1'b0;
      end else if (eng_pend && m_rready === 1'b1 && !m_arready) begin
        m_rvalid = 1'b1; m_rdata = eng_addr ^ 32'hA5A50000; m_rresp = 2'b00; rv_drv = 1'b1;
      end
      if (s_rvalid !== 2'b00) begin
        chk($sformatf("rr_rdata%0d", nresp), {s_rvalid, s_rresp, s_rdata},
            {s_rvalid[1] ? 2'b10 : 2'b01, 2'b00, (s_rvalid[1] ? 32'h20 : 32'h10) ^ 32'hA5A50000});
        nresp++;
      end
    end
    tick();
    s_rready = 2'b00; m_arready = 1'b0; m_rvalid = 1'b0;
    chk("rr_order", {ngrant, order}, {32'd6, 6'b101010});
    chk("rr_marvalid_count", marv_rises - marv0, 6);
    chk("rr_idle", {busy, s_arvalid}, 3'b000);

    // ---- D: engine silent -> SLVERR, one timeout pulse, late beat drained ----
    to_pulses = 0;
    s_araddr[31:0] = 32'h200;
    s_arvalid = 2'b01;
    g = 0;
    while (s_arready[0] !== 1'b1 && g < 20) begin tick(); g++; end
    tick();
    s_arvalid = 2'b00;
    g = 0;
    while (m_arvalid !== 1'b1 && g < 20) begin tick(); g++; end
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    nw = 0; g = 0;
    while (s_rvalid[0] !== 1'b1 && g < 40) begin
      if (m_rready === 1'b1) nw++;
      tick(); g++;
    end
    chk("d_wait_cycles", nw, 16);
    chk("d_rvalid", s_rvalid, 2'b01);
    chk("d_slverr", {timeout, s_rresp, s_rdata}, {1'b1, 2'b10, 32'h0});
    repeat (3) tick();
    s_rready = 2'b01;
    tick();
    s_rready = 2'b00;
    chk("d_drain", {m_rready, busy, s_rvalid}, 4'b1100);
    m_rvalid = 1'b1; m_rdata = 32'hBAD0BAD0; m_rresp = 2'b00;
    tick();
    m_rvalid = 1'b0;
    chk("d_drained", {m_rready, busy, s_rvalid}, 4'b0000);
    tick(); tick();
    chk("d_not_forwarded", s_rvalid, 2'b00);
    chk("d_pulses", to_pulses, 1);
    do_read(0, 32'h204, 5, 0, 32'h12345678, 2'b00, "d_next");

    // ---- E: response back-pressure, and engine error passed through ----
    do_read(0, 32'h300, 2, 10, 32'hCAFEF00D, 2'b00, "e_bp");
    do_read(1, 32'h40, 1, 2, 32'h0000BEEF, 2'b10, "e_slverr");

    // ---- F: reset during WAIT_R, then a clean S1 read ----
    s_araddr[31:0] = 32'h500;
    s_arvalid = 2'b01;
    g = 0;
    while (s_arready[0] !== 1'b1 && g < 20) begin tick(); g++; end
    tick();
    s_arvalid = 2'b00;
    g = 0;
    while (m_arvalid !== 1'b1 && g < 20) begin tick(); g++; end
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    repeat (3) tick();
    chk("f_in_wait", {m_rready, busy}, 2'b11);
    ARESETn = 1'b0;
    #1;
    chk("f_async_ctrl", {s_arready, s_rvalid, s_rresp, m_arvalid, m_rready, timeout, busy}, '0);
    chk("f_async_data", {s_rdata, m_araddr}, '0);
    tick(); tick();
    ARESETn = 1'b1;
    tick();
    do_read(1, 32'h1000, 4, 0, 32'h0BADF00D, 2'b00, "f_s1");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
